// File: rtl/dmem_resp.sv
// Data-memory responder for the MEM-stage port.
// One request in flight, fixed latency, byte/half/word lanes.
module dmem_resp #(
   parameter int XLEN        = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   input  logic [1:0]      req_size,
   input  logic            req_unsigned,
   input  logic [XLEN-1:0] req_pc,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [XLEN-1:0] rsp_rdata,
   output logic            rsp_err,
   output logic [XLEN-1:0] rsp_pc
);

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       rdy_q;

   logic            we_q;
   logic            uns_q;
   logic            err_q;
   logic [1:0]      size_q;
   logic [1:0]      lane_q;
   logic [AW-1:0]   idx_q;
   logic [XLEN-1:0] pc_q;

   logic [31:0] mem_q [DEPTH_WORDS];

   logic          accept;
   logic          req_err;
   logic [AW-1:0] req_idx;
   logic [3:0]    be;
   logic [31:0]   wd;

   logic [31:0]     word;
   logic [7:0]      byte_v;
   logic [15:0]     half_v;
   logic [XLEN-1:0] ld_data;

   // rdy_q keeps req_ready low until the first edge after reset release
   assign req_ready = (state_q == S_IDLE) && rdy_q;
   assign accept    = req_valid && req_ready;
   assign req_idx   = req_addr[AW+1:2];

   // Request legality: size, alignment and array range
   always_comb begin
      req_err = 1'b0;
      unique case (1'b1)
         (req_size == 2'b11):                   req_err = 1'b1;
         (req_size == 2'b01) && req_addr[0]:    req_err = 1'b1;
         (req_size == 2'b00) && |req_addr[1:0]: req_err = 1'b1;
         default:                               req_err = 1'b0;
      endcase
      if (req_addr[XLEN-1:2] >= (XLEN-2)'(DEPTH_WORDS)) begin
         req_err = 1'b1;
      end
   end

   // Store lane enables and lane-replicated write data
   always_comb begin
      be = 4'b0000;
      wd = req_wdata[31:0];
      unique case (req_size)
         2'b00: be = 4'b1111;
         2'b01: begin
            be = req_addr[1] ? 4'b1100 : 4'b0011;
            wd = {2{req_wdata[15:0]}};
         end
         2'b10: begin
            be = 4'b0001 << req_addr[1:0];
            wd = {4{req_wdata[7:0]}};
         end
         default: be = 4'b0000;
      endcase
   end

   // Array write on the accept edge; contents are never reset
   always_ff @(posedge clk) begin
      if (accept && req_we && !req_err) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
               mem_q[req_idx][8*i +: 8] <= wd[8*i +: 8];
            end
         end
      end
   end

   // State, latency counter and release flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdy_q   <= 1'b1;
      end
   end

   // Next-state: accept, count out the wait, hold until taken
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               cnt_d   = 4'd0;
               state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_d == LAT_M1) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // Latch the request attributes the response depends on
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         we_q   <= 1'b0;
         uns_q  <= 1'b0;
         err_q  <= 1'b0;
         size_q <= 2'b00;
         lane_q <= 2'b00;
         idx_q  <= '0;
         pc_q   <= '0;
      end else if (accept) begin
         we_q   <= req_we;
         uns_q  <= req_unsigned;
         err_q  <= req_err;
         size_q <= req_size;
         lane_q <= req_addr[1:0];
         idx_q  <= req_idx;
         pc_q   <= req_pc;
      end
   end

   // Load path reads the array live, so earlier stores are visible
   always_comb begin
      word    = mem_q[idx_q];
      byte_v  = 8'(word >> {lane_q, 3'b000});
      half_v  = lane_q[1] ? word[31:16] : word[15:0];
      ld_data = '0;
      unique case (size_q)
         2'b00: ld_data = XLEN'(word);
         2'b01: ld_data = {{(XLEN-16){~uns_q & half_v[15]}}, half_v};
         2'b10: ld_data = {{(XLEN-8){~uns_q & byte_v[7]}}, byte_v};
         default: ld_data = '0;
      endcase
   end

   assign rsp_valid = (state_q == S_RESP);
   assign rsp_err   = rsp_valid && err_q;
   assign rsp_pc    = rsp_valid ? pc_q : '0;
   assign rsp_rdata = (rsp_valid && !err_q && !we_q) ? ld_data : '0;

endmodule
